// File: rtl/mac_result_divider.sv
//==============================================================================
// mac_result_divider : restoring divider, one quotient bit per clock,
//                      start/busy/done handshake.
// Revision 1.0
//==============================================================================
`default_nettype none

module mac_result_divider #(
  parameter int DIVIDEND_W = 48,
  parameter int DIVISOR_W  = 18
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIVIDEND_W - 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [DIVIDEND_W-1:0] shreg_q, shreg_d;
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  done_q, done_d;
  logic                  dbz_q, dbz_d;
  logic                  dz_pend_q, dz_pend_d;

  logic [DIVISOR_W+1:0]  partial;
  logic [DIVISOR_W+1:0]  trial;
  logic                  q_bit;
  logic [DIVISOR_W:0]    rem_next;
  logic [DIVIDEND_W-1:0] shreg_next;
  logic                  accept;

  // Quotient bits shift in at the LSB as dividend bits leave at the MSB.
  always_comb begin
    partial    = {rem_q, shreg_q[DIVIDEND_W-1]};
    trial      = partial - {2'b00, dsr_q};
    q_bit      = ~trial[DIVISOR_W+1];
    rem_next   = q_bit ? trial[DIVISOR_W:0] : partial[DIVISOR_W:0];
    shreg_next = {shreg_q[DIVIDEND_W-2:0], q_bit};
  end

  assign accept = (state_q == S_IDLE) && !dz_pend_q && start;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && (divisor != '0)) state_d = S_RUN;
      S_RUN:   if (cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A zero divisor is held for one cycle in rem_q before being reported.
  always_comb begin
    shreg_d     = shreg_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    dz_pend_d   = 1'b0;
    if (state_q == S_IDLE) begin
      if (dz_pend_q) begin
        done_d      = 1'b1;
        dbz_d       = 1'b1;
        quotient_d  = '1;
        remainder_d = rem_q[DIVISOR_W-1:0];
      end else if (accept) begin
        if (divisor != '0) begin
          shreg_d = dividend;
          dsr_d   = divisor;
          rem_d   = '0;
          cnt_d   = CNT_LOAD;
        end else begin
          dz_pend_d = 1'b1;
          rem_d     = {1'b0, dividend[DIVISOR_W-1:0]};
        end
      end
    end else begin
      shreg_d = shreg_next;
      rem_d   = rem_next;
      cnt_d   = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        quotient_d  = shreg_next;
        remainder_d = rem_next[DIVISOR_W-1:0];
        done_d      = 1'b1;
        dbz_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q     <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      dz_pend_q   <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      dz_pend_q   <= dz_pend_d;
    end
  end

  always_comb begin
    busy        = (state_q == S_RUN);
    done        = done_q;
    quotient    = quotient_q;
    remainder   = remainder_q;
    div_by_zero = dbz_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_mac_result_divider.sv
//==============================================================================
// tb_mac_result_divider : directed scoreboard bench for mac_result_divider.
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_mac_result_divider;

  localparam int DW = 48;
  localparam int SW = 18;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic [DW-1:0] dividend;
  logic [SW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [SW-1:0] remainder;
  logic          div_by_zero;

  typedef struct packed {
    logic [DW-1:0] q;
    logic [SW-1:0] r;
    logic          dbz;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  mac_result_divider #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [DW-1:0] a, input logic [SW-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a[SW-1:0]; e.dbz = 1'b1;
    end else begin
      e.q = a / DW'(b); e.r = SW'(a % DW'(b)); e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Drive one start pulse; returns after the accepting edge has passed.
  task automatic kick(input logic [DW-1:0] a, input logic [SW-1:0] b, input bit push);
    if (push) sb.push_back(model(a, b));
    @(negedge clock);
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_quot"}, quotient, e.q);
      chk({tag, "_rem"}, remainder, e.r);
      chk({tag, "_dbz"}, div_by_zero, e.dbz);
    end
  endtask

  // Waits for done counting edges since accept (n0 already elapsed).
  task automatic wait_done(input string tag, input int n0, input int exp_lat);
    int  n;
    bit  busy_seen;
    n = n0;
    busy_seen = 1'b0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
      if (busy === 1'b1 && done !== 1'b1) busy_seen = 1'b1;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    if (exp_lat == 1) chk({tag, "_busy_never"}, busy_seen, 1'b0);
    compare_pop(tag);
    @(negedge clock);
    chk({tag, "_done_one_cycle"}, done, 1'b0);
  endtask

  initial begin
    int  g;
    bit  done_seen;
    logic [DW-1:0] held_q;

    reset_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_quot", quotient, '0);
    chk("rst_rem", remainder, '0);
    chk("rst_dbz", div_by_zero, 1'b0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    kick(48'd100, 18'd7, 1'b1);
    chk("d100_busy", busy, 1'b1);
    wait_done("d100_7", 0, 48);

    kick(48'hFFFF_FFFF_FFFF, 18'h3FFFF, 1'b1);
    wait_done("max_3ffff", 0, 48);
    kick(48'hFFFF_FFFF_FFFF, 18'd1, 1'b1);
    wait_done("max_1", 0, 48);
    kick(48'd5, 18'd9, 1'b1);
    wait_done("d5_9", 0, 48);
    kick(48'd0, 18'd3, 1'b1);
    wait_done("d0_3", 0, 48);

    kick(48'h12345, 18'd0, 1'b1);
    chk("dz_busy", busy, 1'b0);
    wait_done("dz", 0, 1);

    for (int i = 0; i < 3; i++) begin
      logic [DW-1:0] a;
      logic [SW-1:0] b;
      a = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
      b = SW'($urandom_range(1, 262143));
      kick(a, b, 1'b1);
      wait_done("rand", 0, 48);
    end

    // start during RUN is ignored and outputs hold the previous result.
    held_q = quotient;
    kick(48'd100, 18'd7, 1'b1);
    repeat (19) @(negedge clock);
    dividend = 48'd5; divisor = 18'd9; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("ign_busy", busy, 1'b1);
    chk("ign_hold_quot", quotient, held_q);
    wait_done("ignore", 20, 48);

    // Mid-run reset clears outputs and suppresses done.
    kick(48'd100, 18'd7, 1'b0);
    repeat (30) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_quot", quotient, '0);
    chk("mrst_rem", remainder, '0);
    chk("mrst_dbz", div_by_zero, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    done_seen = 1'b0;
    repeat (60) begin
      @(negedge clock);
      if (done === 1'b1) done_seen = 1'b1;
    end
    chk("mrst_no_done", done_seen, 1'b0);

    // Back-to-back with start held across the done cycle.
    sb.push_back(model(48'd1000, 18'd10));
    sb.push_back(model(48'd999, 18'd10));
    @(negedge clock);
    dividend = 48'd1000; divisor = 18'd10; start = 1'b1;
    @(negedge clock);
    g = 0;
    while (done !== 1'b1 && g < 200) begin
      @(negedge clock);
      g++;
    end
    chk("b2b_first_latency", g, 48);
    compare_pop("b2b_first");
    dividend = 48'd999;
    g = 0;
    while (g < 200) begin
      @(negedge clock);
      g++;
      if (g == 1) begin
        start = 1'b0;
        chk("b2b_second_busy", busy, 1'b1);
      end
      if (done === 1'b1) break;
    end
    chk("b2b_gap", g, 49);
    compare_pop("b2b_second");

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
